pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 70 +++++++
 tb/tb_pipe_skid_reg.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer with registered ready, flush and transfer counter
module pipe_skid_reg #(
  parameter int WIDTH   = 16,
  parameter int NFIELDS = 7,
  parameter int DEST_W  = 3,
  parameter int CNT_W   = 16,
  parameter int PW      = NFIELDS * WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PW-1:0]     in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_count
);
  logic [PW-1:0]     r_main_data, r_skid_data;
  logic [DEST_W-1:0] r_main_dest, r_skid_dest;
  logic              r_main_v, r_skid_v;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_in_hs, w_out_hs;
  // ready depends only on registered skid state, never on out_ready
  assign in_ready   = ~r_skid_v & reset_n;
  assign w_in_hs    = in_valid & in_ready;
  assign w_out_hs   = r_main_v & out_ready;
  assign out_valid  = r_main_v;
  assign out_data   = r_main_data;
  assign out_dest   = r_main_dest;
  assign occupancy  = {1'b0, r_main_v} + {1'b0, r_skid_v};
  assign xfer_count = r_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main_data <= '0;
      r_main_dest <= '0;
      r_skid_data <= '0;
      r_skid_dest <= '0;
      r_main_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_out_hs) r_cnt <= r_cnt + 1'b1;
      if (flush) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (r_skid_v) begin
        if (w_out_hs) begin
          r_main_data <= r_skid_data;
          r_main_dest <= r_skid_dest;
          r_skid_v    <= 1'b0;
        end
      end else if (w_in_hs && (!r_main_v || w_out_hs)) begin
        r_main_data <= in_data;
        r_main_dest <= in_dest;
        r_main_v    <= 1'b1;
      end else if (w_in_hs) begin
        r_skid_data <= in_data;
        r_skid_dest <= in_dest;
        r_skid_v    <= 1'b1;
      end else if (w_out_hs) begin
        r_main_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench for pipe_skid_reg, with a CNT_W=4 twin for counter wrap
module tb_pipe_skid_reg;
  localparam int W = 16, NF = 7, DW = 3, PW = W * NF;
  logic          clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [PW-1:0] in_data = '0;
  logic [DW-1:0] in_dest = '0;
  logic          in_ready, out_valid, in_ready4, out_valid4;
  logic [PW-1:0] out_data, out_data4;
  logic [DW-1:0] out_dest, out_dest4;
  logic [1:0]    occupancy, occupancy4;
  logic [15:0]   xfer_count;
  logic [3:0]    xfer4;
  int            n_cmp = 0, n_bad = 0, n_xfer = 0;
  logic [PW+DW-1:0] q[$];

  pipe_skid_reg dut (.clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .occupancy(occupancy), .xfer_count(xfer_count));
  pipe_skid_reg #(.CNT_W(4)) dut4 (.clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_dest(out_dest4), .occupancy(occupancy4), .xfer_count(xfer4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd();
    logic [PW-1:0] r;
    for (int i = 0; i < NF; i++) r[i*W +: W] = 16'($urandom);
    return r;
  endfunction

  // drive one cycle, check the pre-edge state against the model, then advance the model
  task automatic step(input logic iv, input logic [PW-1:0] d, input logic [DW-1:0] ds,
                      input logic ordy, input logic fl);
    logic can_in;
    @(negedge clk);
    in_valid = iv; in_data = d; in_dest = ds; out_ready = ordy; flush = fl;
    #1;
    can_in = q.size() < 2;
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("in_ready", 128'(in_ready), 128'(can_in));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("xfer_count", 128'(xfer_count), 128'(n_xfer % 65536));
    chk("xfer_count4", 128'(xfer4), 128'(n_xfer % 16));
    if (q.size() != 0) begin
      chk("out_payload", 128'({out_data, out_dest}), 128'(q[0]));
      if (ordy) begin
        void'(q.pop_front());
        n_xfer++;
      end
    end
    if (fl) q.delete();
    else if (iv && can_in) q.push_back({d, ds});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; in_valid = 1; in_data = rnd(); out_ready = 1; flush = 1;
    #1 chk("in_ready_in_reset", 128'(in_ready), 128'(0));
    @(negedge clk);
    reset_n = 1; in_valid = 0; out_ready = 0; flush = 0;
    q.delete();
    n_xfer = 0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_xfer_count", 128'(xfer_count), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_dest", 128'(out_dest), 128'(0));
  endtask

  initial begin
    logic [PW-1:0] d;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (2) step(0, '0, 0, 0, 0);
    d = '0; d[15:0] = 16'h1234;
    step(1, d, 3'd5, 1, 0);
    @(posedge clk); #1;
    chk("single_field0", 128'(out_data[15:0]), 128'h1234);
    chk("single_dest", 128'(out_dest), 128'd5);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    chk("single_count", 128'(xfer_count), 128'd1);
    do_reset();
    step(1, rnd(), 3'd1, 0, 0);
    step(1, rnd(), 3'd2, 0, 0);
    step(1, rnd(), 3'd3, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    chk("bp_count", 128'(xfer_count), 128'd2);
    do_reset();
    for (int i = 0; i < 100; i++) step(1, rnd(), 3'($urandom), 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    chk("stream_count", 128'(xfer_count), 128'd100);
    step(1, rnd(), 3'd1, 0, 0);
    step(1, rnd(), 3'd2, 0, 0);
    step(1, rnd(), 3'd7, 0, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    step(1, rnd(), 3'd4, 0, 0);
    step(1, rnd(), 3'd5, 1, 1);
    step(0, '0, 0, 1, 0);
    step(1, rnd(), 3'd1, 0, 0);
    step(1, rnd(), 3'd2, 0, 0);
    do_reset();
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 17; i++) step(1, rnd(), 3'($urandom), 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    chk("wrap_count4", 128'(xfer4), 128'd1);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 2) != 0), rnd(), 3'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 29) == 0));
    step(0, '0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
